// File: rtl/vga_fetch_pkg.sv
// Shared types and helpers for the video-fetch pacer.
//   fetch_state_e : burst FSM states
//   fetch_src_e   : fetch_dat source select (SRC_ZERO / SRC_CACHE / SRC_FML)
//   clog2()       : counter width helper, never returns less than 1
package vga_fetch_pkg;

  localparam int unsigned PIX_DIV_W      = 2;
  localparam int unsigned UNDERRUN_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StTry,
    StChk,
    StCstr,
    StFmlReq,
    StFstr,
    StZstr
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_CACHE = 2'd1,
    SRC_FML   = 2'd2
  } fetch_src_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    if (width == 0) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/vga_fetch_pacer_fml_pix_tick_div.sv
// Pixel tick divider and FIFO underrun monitor.
//   clk_i/rst_i       : clock, async active-high reset
//   pix_div_i         : tick period = pix_div_i + 1 clocks, sampled at reload
//   fifo_empty_i      : pixel FIFO empty
//   underrun_clr_i    : clears the sticky flag and counter, wins over a set
//   pix_tick_o        : raw pixel clock enable
//   fifo_rd_o         : pix_tick_o qualified by a non-empty FIFO
//   underrun_o        : sticky underrun flag
//   underrun_cnt_o    : saturating underrun tick count
module vga_pix_tick_div
  import vga_fetch_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PIX_DIV_W-1:0]      pix_div_i,
  input  logic                      fifo_empty_i,
  input  logic                      underrun_clr_i,
  output logic                      pix_tick_o,
  output logic                      fifo_rd_o,
  output logic                      underrun_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  logic [PIX_DIV_W-1:0]      cnt_q, cnt_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
  logic                      tick;

  always_comb begin
    tick       = (cnt_q == '0);
    cnt_d      = tick ? pix_div_i : cnt_q - PIX_DIV_W'(1);
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    if (underrun_clr_i) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
    end else if (tick && fifo_empty_i) begin
      underrun_d = 1'b1;
      if (ucnt_q != '1) ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign pix_tick_o     = tick & ~rst_i;
  assign fifo_rd_o      = tick & ~fifo_empty_i & ~rst_i;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

// File: rtl/vga_fetch_pacer_fml.sv
// Video-fetch pacer: paces CRTC/sequencer steps, fetches each burst from the
// DCB first and falls back to FML, zero-fills on FML timeout.
//   cache_en/start_addr/lcd_stb/lcd_adr : sequencer side request
//   step/fetch_dat                      : sequencer advance and data
//   fifo_level/fifo_full/fifo_empty     : pixel FIFO status; fifo_rd pops it
//   pix_div/pix_tick                    : pixel clock enable divider
//   fml_*                               : FML burst master
//   dcb_*                               : DCB (L2) lookup port
//   underrun/underrun_cnt/underrun_clr  : FIFO underrun monitor
//   fetch_err                           : one-clock pulse on FML timeout
module vga_fetch_pacer_fml
  import vga_fetch_pkg::*;
#(
  parameter int unsigned FML_DEPTH = 20,
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LVL_W     = 10,
  parameter int unsigned BURST_THR = 300,
  parameter int unsigned TMO_CYC   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cache_en,
  input  logic [PIX_DIV_W-1:0]      pix_div,
  input  logic [15:0]               start_addr,
  input  logic                      lcd_stb,
  input  logic [FML_DEPTH-2:0]      lcd_adr,
  output logic [DW-1:0]             fetch_dat,
  output logic                      step,
  input  logic [LVL_W-1:0]          fifo_level,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  output logic                      pix_tick,
  output logic [FML_DEPTH-1:0]      fml_adr,
  output logic                      fml_stb,
  input  logic                      fml_ack,
  input  logic [DW-1:0]             fml_di,
  output logic                      dcb_stb,
  output logic [FML_DEPTH-1:0]      dcb_adr,
  input  logic [DW-1:0]             dcb_dat,
  input  logic                      dcb_hit,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  input  logic                      underrun_clr,
  output logic                      fetch_err
);

  localparam int unsigned    BeatW    = clog2(BURST_LEN);
  localparam int unsigned    TmoW     = clog2(TMO_CYC);
  localparam int unsigned    WordW    = FML_DEPTH - 1;
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [TmoW-1:0]  TmoOne   = TmoW'(1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TMO_CYC - 1);

  fetch_state_e         state_q, state_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [FML_DEPTH-1:0] fml_adr_q, fml_adr_d;

  fetch_src_e           src;
  logic [BeatW-1:0]     lookup;
  logic                 fifo_ok;
  logic                 step_raw, fml_stb_raw, dcb_stb_raw, fetch_err_raw;
  logic [WordW-1:0]     word_adr;
  logic [FML_DEPTH-1:0] next_adr;
  logic                 unused_start_lsb;

  // start_addr is in 2-word units above bit 0; the sum wraps at the word width.
  assign word_adr         = lcd_adr + WordW'({start_addr[15:1], 2'b00});
  assign next_adr         = {word_adr, 1'b0};
  assign unused_start_lsb = start_addr[0];

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    fml_adr_d     = fml_adr_q;
    src           = SRC_ZERO;
    lookup        = beat_q;
    step_raw      = 1'b0;
    fml_stb_raw   = 1'b0;
    dcb_stb_raw   = 1'b0;
    fetch_err_raw = 1'b0;
    fifo_ok       = (32'(fifo_level) <= BURST_THR) && !fifo_full;

    unique case (state_q)
      StIdle: begin
        if (fifo_ok) begin
          step_raw = 1'b1;
          if (lcd_stb) begin
            fml_adr_d = next_adr;
            state_d   = StDelay;
          end
        end
      end
      StDelay: begin
        step_raw = 1'b1;
        state_d  = cache_en ? StTry : StFmlReq;
      end
      StTry: begin
        dcb_stb_raw = 1'b1;
        step_raw    = 1'b1;
        beat_d      = '0;
        state_d     = StChk;
      end
      StChk: begin
        // Hit data for beat N arrives while beat N+1 is being looked up.
        src    = SRC_CACHE;
        lookup = beat_q + BeatOne;
        if (dcb_hit) begin
          dcb_stb_raw = 1'b1;
          step_raw    = 1'b1;
          beat_d      = beat_q + BeatOne;
          state_d     = StCstr;
        end else begin
          state_d = StFmlReq;
        end
      end
      StCstr: begin
        src         = SRC_CACHE;
        lookup      = beat_q + BeatOne;
        step_raw    = 1'b1;
        beat_d      = beat_q + BeatOne;
        dcb_stb_raw = (beat_q < BeatLast);
        if (beat_q == BeatLast) state_d = StIdle;
      end
      StFmlReq: begin
        // First FML beat is presented on the ack cycle.
        src         = SRC_FML;
        fml_stb_raw = 1'b1;
        tmo_d       = tmo_q + TmoOne;
        if (fml_ack) begin
          step_raw = 1'b1;
          beat_d   = BeatOne;
          state_d  = StFstr;
        end else if (tmo_q == TmoLast) begin
          fetch_err_raw = 1'b1;
          beat_d        = BeatOne;
          state_d       = StZstr;
        end
      end
      StFstr: begin
        src      = SRC_FML;
        step_raw = 1'b1;
        beat_d   = beat_q + BeatOne;
        if (beat_q == BeatLast) state_d = StIdle;
      end
      StZstr: begin
        // Zero-filled steps keep the sequencer aligned after an aborted fetch.
        step_raw = 1'b1;
        beat_d   = beat_q + BeatOne;
        if (beat_q == BeatLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      beat_d = '0;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      tmo_q     <= '0;
      fml_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      fml_adr_q <= fml_adr_d;
    end
  end

  always_comb begin
    unique case (src)
      SRC_CACHE: fetch_dat = dcb_dat;
      SRC_FML:   fetch_dat = fml_di;
      default:   fetch_dat = '0;
    endcase
    if (rst) fetch_dat = '0;
  end

  assign step      = step_raw & ~rst;
  assign fml_stb   = fml_stb_raw & ~rst;
  assign dcb_stb   = dcb_stb_raw & ~rst;
  assign fetch_err = fetch_err_raw & ~rst;
  assign fml_adr   = fml_adr_q;
  assign dcb_adr   = rst ? '0 : fml_adr_q + FML_DEPTH'({lookup, 1'b0});

  vga_pix_tick_div u_pix_tick_div (
    .clk_i          (clk),
    .rst_i          (rst),
    .pix_div_i      (pix_div),
    .fifo_empty_i   (fifo_empty),
    .underrun_clr_i (underrun_clr),
    .pix_tick_o     (pix_tick),
    .fifo_rd_o      (fifo_rd),
    .underrun_o     (underrun),
    .underrun_cnt_o (underrun_cnt)
  );

endmodule

// File: tb/tb_vga_fetch_pacer_fml.sv
module tb_vga_fetch_pacer_fml;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_en;
  logic [1:0]  pix_div;
  logic [15:0] start_addr;
  logic        lcd_stb;
  logic [18:0] lcd_adr;
  logic [15:0] fetch_dat;
  logic        step;
  logic [9:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        pix_tick;
  logic [19:0] fml_adr;
  logic        fml_stb;
  logic        fml_ack;
  logic [15:0] fml_di;
  logic        dcb_stb;
  logic [19:0] dcb_adr;
  logic [15:0] dcb_dat;
  logic        dcb_hit;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic        underrun_clr;
  logic        fetch_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  // Cache responder: data and hit are returned one clock after the lookup.
  logic        hit_mode;
  logic        last_stb;
  logic [15:0] last_adr;

  always #5 clk = ~clk;

  function automatic logic [15:0] cache_word(input logic [15:0] adr);
    return adr ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] fml_word(input int k);
    return 16'h3C00 + 16'(k * 7);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      last_stb <= 1'b0;
      last_adr <= 16'h0;
    end else begin
      last_stb <= dcb_stb;
      last_adr <= dcb_adr[15:0];
    end
  end

  assign dcb_dat = last_stb ? cache_word(last_adr) : 16'h0;
  assign dcb_hit = last_stb & hit_mode;

  vga_fetch_pacer_fml dut (
    .clk          (clk),
    .rst          (rst),
    .cache_en     (cache_en),
    .pix_div      (pix_div),
    .start_addr   (start_addr),
    .lcd_stb      (lcd_stb),
    .lcd_adr      (lcd_adr),
    .fetch_dat    (fetch_dat),
    .step         (step),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .pix_tick     (pix_tick),
    .fml_adr      (fml_adr),
    .fml_stb      (fml_stb),
    .fml_ack      (fml_ack),
    .fml_di       (fml_di),
    .dcb_stb      (dcb_stb),
    .dcb_adr      (dcb_adr),
    .dcb_dat      (dcb_dat),
    .dcb_hit      (dcb_hit),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .underrun_clr (underrun_clr),
    .fetch_err    (fetch_err)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; lcd_stb = 1'b1; fml_ack = 1'b1;
    #1;
    vectors++;
    if ({step, fml_stb, dcb_stb, fifo_rd, pix_tick, fetch_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 000000",
               {step, fml_stb, dcb_stb, fifo_rd, pix_tick, fetch_err});
    end
    vectors++;
    if ({fml_adr, dcb_adr, fetch_dat, underrun, underrun_cnt} !== 73'h0) begin
      miscompares++;
      $display("FAIL reset_data got adr=%h dadr=%h dat=%h ur=%b cnt=%h want all 0",
               fml_adr, dcb_adr, fetch_dat, underrun, underrun_cnt);
    end
    @(negedge clk);
    rst = 1'b0; lcd_stb = 1'b0; fml_ack = 1'b0;
    #1;
    vectors++;
    if ({step, fml_stb, pix_tick} !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_release got %b want 101", {step, fml_stb, pix_tick});
    end
  endtask

  task automatic test_cache_hit();
    logic [15:0] want;
    logic [2:0]  exp3;
    @(negedge clk);
    cache_en = 1'b1; hit_mode = 1'b1; start_addr = 16'h0010; lcd_adr = 19'h00100;
    lcd_stb = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(cache_word(16'h0240 + 16'(2 * i)));
    #1;
    vectors++;
    if (step !== 1'b1) begin
      miscompares++; $display("FAIL hit_accept_step got %b want 1", step);
    end
    @(negedge clk);
    lcd_stb = 1'b0;
    #1;
    vectors++;
    if (fml_adr !== 20'h00240) begin
      miscompares++; $display("FAIL hit_fml_adr got %h want 00240", fml_adr);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      exp3 = {1'b1, (i <= 7), 1'b0};
      vectors++;
      if ({step, dcb_stb, fml_stb} !== exp3) begin
        miscompares++;
        $display("FAIL hit_ctl[%0d] got %b want %b", i, {step, dcb_stb, fml_stb}, exp3);
      end
      if (i <= 7) begin
        vectors++;
        if (dcb_adr !== 20'h00240 + 20'(2 * i)) begin
          miscompares++;
          $display("FAIL hit_dcb_adr[%0d] got %h want %h", i, dcb_adr, 20'h00240 + 20'(2 * i));
        end
      end
      if (i >= 1 && i <= 8) begin
        if (exp_q.size() == 0) want = 16'hxxxx;
        else want = exp_q.pop_front();
        vectors++;
        if (fetch_dat !== want) begin
          miscompares++; $display("FAIL hit_data[%0d] got %h want %h", i, fetch_dat, want);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL hit_leftover got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_cache_miss();
    logic [15:0] want;
    @(negedge clk);
    cache_en = 1'b1; hit_mode = 1'b0; start_addr = 16'h0000; lcd_adr = 19'h00020;
    lcd_stb = 1'b1;
    @(negedge clk);
    lcd_stb = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({step, dcb_stb, fml_stb} !== 3'b110) begin
      miscompares++; $display("FAIL miss_try got %b want 110", {step, dcb_stb, fml_stb});
    end
    @(negedge clk); #1;
    vectors++;
    if ({step, dcb_stb, fml_stb} !== 3'b000) begin
      miscompares++; $display("FAIL miss_chk got %b want 000", {step, dcb_stb, fml_stb});
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); #1;
      vectors++;
      if ({step, dcb_stb, fml_stb} !== 3'b001) begin
        miscompares++;
        $display("FAIL miss_req[%0d] got %b want 001", j, {step, dcb_stb, fml_stb});
      end
    end
    vectors++;
    if (fml_adr !== 20'h00040) begin
      miscompares++; $display("FAIL miss_fml_adr got %h want 00040", fml_adr);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      fml_ack = (k == 0);
      fml_di  = fml_word(k);
      exp_q.push_back(fml_word(k));
      #1;
      vectors++;
      if ({step, fml_stb} !== {1'b1, (k == 0)}) begin
        miscompares++;
        $display("FAIL miss_beat_ctl[%0d] got %b want %b", k, {step, fml_stb}, {1'b1, (k == 0)});
      end
      if (exp_q.size() == 0) want = 16'hxxxx;
      else want = exp_q.pop_front();
      vectors++;
      if (fetch_dat !== want) begin
        miscompares++; $display("FAIL miss_data[%0d] got %h want %h", k, fetch_dat, want);
      end
    end
    @(negedge clk);
    fml_ack = 1'b0; fml_di = 16'hFFFF;
    #1;
    vectors++;
    if ({step, fml_stb, fetch_dat} !== {2'b10, 16'h0000}) begin
      miscompares++;
      $display("FAIL miss_idle got step=%b stb=%b dat=%h want 1 0 0000", step, fml_stb, fetch_dat);
    end
  endtask

  task automatic test_timeout();
    int err_seen;
    @(negedge clk);
    cache_en = 1'b0; fml_ack = 1'b0; lcd_adr = 19'h00055; start_addr = 16'h0000;
    lcd_stb = 1'b1;
    @(negedge clk);
    lcd_stb = 1'b0;
    #1;
    vectors++;
    if ({step, fml_stb} !== 2'b10) begin
      miscompares++; $display("FAIL tmo_delay got %b want 10", {step, fml_stb});
    end
    err_seen = 0;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk); #1;
      if (fetch_err === 1'b1) err_seen++;
      vectors++;
      if ({step, fml_stb, fetch_err} !== {2'b01, (j == 64)}) begin
        miscompares++;
        $display("FAIL tmo_req[%0d] got %b want %b", j, {step, fml_stb, fetch_err},
                 {2'b01, (j == 64)});
      end
    end
    vectors++;
    if (err_seen != 1) begin
      miscompares++; $display("FAIL tmo_err_count got %0d want 1", err_seen);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      fml_di = 16'hBEEF;
      #1;
      vectors++;
      if ({step, fml_stb, fetch_err, fetch_dat} !== {3'b100, 16'h0000}) begin
        miscompares++;
        $display("FAIL tmo_zfill[%0d] got ctl=%b dat=%h want 100 0000", k,
                 {step, fml_stb, fetch_err}, fetch_dat);
      end
    end
    @(negedge clk);
    fifo_full = 1'b1;
    #1;
    vectors++;
    if ({step, fml_stb} !== 2'b00) begin
      miscompares++; $display("FAIL tmo_back_idle got %b want 00", {step, fml_stb});
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_backpressure_wrap();
    @(negedge clk);
    cache_en = 1'b0; fifo_level = 10'd301; lcd_stb = 1'b1;
    lcd_adr = 19'h7FFFF; start_addr = 16'hFFFE;
    #1;
    vectors++;
    if (step !== 1'b0) begin
      miscompares++; $display("FAIL bp_level301 got step=%b want 0", step);
    end
    @(negedge clk); #1;
    vectors++;
    if ({step, fml_adr} !== {1'b0, 20'h000AA}) begin
      miscompares++;
      $display("FAIL bp_no_accept got step=%b adr=%h want 0 000AA", step, fml_adr);
    end
    @(negedge clk);
    lcd_stb = 1'b0; fifo_level = 10'd300;
    #1;
    vectors++;
    if (step !== 1'b1) begin
      miscompares++; $display("FAIL bp_level300 got step=%b want 1", step);
    end
    @(negedge clk);
    fifo_level = 10'd0; fifo_full = 1'b1;
    #1;
    vectors++;
    if (step !== 1'b0) begin
      miscompares++; $display("FAIL bp_full got step=%b want 0", step);
    end
    @(negedge clk);
    fifo_full = 1'b0; lcd_stb = 1'b1;
    @(negedge clk);
    lcd_stb = 1'b0;
    #1;
    vectors++;
    if (fml_adr !== 20'h3FFF6) begin
      miscompares++; $display("FAIL wrap_fml_adr got %h want 3FFF6", fml_adr);
    end
    @(negedge clk);
    fml_ack = 1'b1;
    #1;
    vectors++;
    if ({step, fml_stb} !== 2'b11) begin
      miscompares++; $display("FAIL wrap_ack got %b want 11", {step, fml_stb});
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      fml_ack = 1'b0;
    end
    @(negedge clk);
    fifo_full = 1'b1;
    #1;
    vectors++;
    if ({step, fml_stb} !== 2'b00) begin
      miscompares++; $display("FAIL wrap_back_idle got %b want 00", {step, fml_stb});
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_pixel_underrun();
    logic exp_tick;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      if (c == 0) pix_div = 2'd3;
      if (c == 6) pix_div = 2'd1;
      underrun_clr = (c == 0) || (c == 20);
      fifo_empty   = (c >= 13 && c <= 18) || (c == 20);
      #1;
      exp_tick = (c <= 8) ? (c % 4 == 0) : (c % 2 == 0);
      vectors++;
      if ({pix_tick, fifo_rd} !== {exp_tick, exp_tick & ~fifo_empty}) begin
        miscompares++;
        $display("FAIL pix_tick[%0d] got %b want %b", c, {pix_tick, fifo_rd},
                 {exp_tick, exp_tick & ~fifo_empty});
      end
      if (c == 13 || c == 21) begin
        vectors++;
        if ({underrun, underrun_cnt} !== 17'h0) begin
          miscompares++;
          $display("FAIL underrun_clear[%0d] got %b/%0d want 0/0", c, underrun, underrun_cnt);
        end
      end
      if (c == 19 || c == 20) begin
        vectors++;
        if ({underrun, underrun_cnt} !== {1'b1, 16'd3}) begin
          miscompares++;
          $display("FAIL underrun_set[%0d] got %b/%0d want 1/3", c, underrun, underrun_cnt);
        end
      end
    end
    @(negedge clk);
    underrun_clr = 1'b0; fifo_empty = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] want;
    @(negedge clk);
    cache_en = 1'b0; start_addr = 16'h0000; lcd_adr = 19'h01234; lcd_stb = 1'b1;
    @(negedge clk);
    lcd_stb = 1'b0;
    #1;
    vectors++;
    if (fml_adr !== 20'h02468) begin
      miscompares++; $display("FAIL rstm_fml_adr got %h want 02468", fml_adr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fml_ack = (k == 0);
      fml_di  = fml_word(k + 20);
      exp_q.push_back(fml_word(k + 20));
      #1;
      if (exp_q.size() == 0) want = 16'hxxxx;
      else want = exp_q.pop_front();
      vectors++;
      if ({step, fetch_dat} !== {1'b1, want}) begin
        miscompares++;
        $display("FAIL rstm_beat[%0d] got %b/%h want 1/%h", k, step, fetch_dat, want);
      end
    end
    @(negedge clk);
    fml_ack = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({step, fml_stb, dcb_stb, fifo_rd, pix_tick, fetch_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstm_ctl got %b want 000000",
               {step, fml_stb, dcb_stb, fifo_rd, pix_tick, fetch_err});
    end
    vectors++;
    if ({fml_adr, dcb_adr, fetch_dat} !== 56'h0) begin
      miscompares++;
      $display("FAIL rstm_data got adr=%h dadr=%h dat=%h want 0", fml_adr, dcb_adr, fetch_dat);
    end
    @(negedge clk);
    fifo_full = 1'b1; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      vectors++;
      if ({step, fml_stb, dcb_stb, fml_adr} !== 23'h0) begin
        miscompares++;
        $display("FAIL rstm_stray[%0d] got %b adr=%h want 000 0", k,
                 {step, fml_stb, dcb_stb}, fml_adr);
      end
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    vectors++;
    if ({step, fml_stb, fetch_dat} !== {2'b10, 16'h0000}) begin
      miscompares++;
      $display("FAIL rstm_idle got step=%b stb=%b dat=%h want 1 0 0000", step, fml_stb, fetch_dat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cache_en = 1'b0; pix_div = 2'd0; start_addr = 16'h0; lcd_stb = 1'b0;
    lcd_adr = 19'h0; fifo_level = 10'd0; fifo_full = 1'b0; fifo_empty = 1'b0;
    fml_ack = 1'b0; fml_di = 16'h0; underrun_clr = 1'b0; hit_mode = 1'b0;
    test_reset();
    test_cache_hit();
    test_cache_miss();
    test_timeout();
    test_backpressure_wrap();
    test_pixel_underrun();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
